// File: rtl/spectrum_peak_pkg.sv
// spectrum_pkg: shared constants, FSM states and result record for spectrum_peak.
// Neighbour fields exist only when PEAK_NEIGHBOR_EN is defined.
package spectrum_pkg;
  localparam int DW = 24;
  localparam int N = 1024;
  localparam int BINW = $clog2(N);
  typedef enum logic {IDLE, SCAN} state_t;
  typedef struct packed {
    logic [BINW-1:0] bin;
    logic [DW-1:0] power;
`ifdef PEAK_NEIGHBOR_EN
    logic [DW-1:0] left;
    logic [DW-1:0] right;
`endif
  } result_t;
endpackage

// File: rtl/spectrum_peak_if.sv
// spectrum_peak_if: power-sample stream in, peak result out (valid/ready) plus status pulses.
// res_left/res_right are present only when PEAK_NEIGHBOR_EN is defined.
interface spectrum_peak_if;
  import spectrum_pkg::*;
  logic in_valid, in_sop, in_eop;
  logic [DW-1:0] in_data;
  logic res_valid, res_ready;
  logic [BINW-1:0] res_bin;
  logic [DW-1:0] res_power;
  logic frame_err, res_overrun;
`ifdef PEAK_NEIGHBOR_EN
  logic [DW-1:0] res_left, res_right;
  modport master (output in_valid, in_sop, in_eop, in_data, res_ready,
                  input res_valid, res_bin, res_power, res_left, res_right, frame_err, res_overrun);
  modport slave (input in_valid, in_sop, in_eop, in_data, res_ready,
                 output res_valid, res_bin, res_power, res_left, res_right, frame_err, res_overrun);
`else
  modport master (output in_valid, in_sop, in_eop, in_data, res_ready,
                  input res_valid, res_bin, res_power, frame_err, res_overrun);
  modport slave (input in_valid, in_sop, in_eop, in_data, res_ready,
                 output res_valid, res_bin, res_power, frame_err, res_overrun);
`endif
endinterface

// File: rtl/spectrum_peak_cmp.sv
// peak_cmp: running maximum over the search window with optional neighbour capture
// (PEAK_NEIGHBOR_EN); peak_o already includes the sample presented this cycle.
module peak_cmp
  import spectrum_pkg::*;
#(
  parameter int BIN_LO = 1,
  parameter int BIN_HI = N/2-1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic            start_i,
  input  logic [BINW-1:0] bin_i,
  input  logic [DW-1:0]   data_i,
  output result_t         peak_o
);
  localparam logic [BINW-1:0] LO = BINW'(BIN_LO);
  localparam logic [BINW-1:0] HI = BINW'(BIN_HI);
  result_t peak_q, base;
  logic in_win, upd;
  assign in_win = bin_i >= LO && bin_i <= HI;
  assign upd = en_i && in_win && data_i > base.power;
`ifdef PEAK_NEIGHBOR_EN
  logic [DW-1:0] prev_q, prev_d, win_data;
  logic pend_q, pend_d;
  assign win_data = in_win ? data_i : '0;
`endif
  always_comb begin
    base = peak_q;
    if (start_i) begin
      base = '0;
      base.bin = LO;
    end
    peak_o = base;
    if (upd) begin
      peak_o.bin = bin_i;
      peak_o.power = data_i;
    end
`ifdef PEAK_NEIGHBOR_EN
    prev_d = en_i ? win_data : prev_q;
    pend_d = start_i ? 1'b0 : pend_q;
    if (upd) begin
      peak_o.left = start_i ? '0 : prev_q;
      peak_o.right = '0;
      pend_d = 1'b1;
    end else if (en_i && pend_d) begin
      // right neighbour is the sample right after the latest maximum
      peak_o.right = win_data;
      pend_d = 1'b0;
    end
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      peak_q <= '0;
`ifdef PEAK_NEIGHBOR_EN
      prev_q <= '0;
      pend_q <= 1'b0;
`endif
    end else begin
      peak_q <= peak_o;
`ifdef PEAK_NEIGHBOR_EN
      prev_q <= prev_d;
      pend_q <= pend_d;
`endif
    end
endmodule

// File: rtl/spectrum_peak.sv
// spectrum_peak: per-frame peak search on FFT power bins with a one-entry result register.
// PEAK_NEIGHBOR_EN adds neighbour-bin powers to the result.
module spectrum_peak
  import spectrum_pkg::*;
#(
  parameter int BIN_LO = 1,
  parameter int BIN_HI = N/2-1
) (
  input logic sys_clk,
  input logic sys_rst,
  spectrum_peak_if.slave bus
);
  state_t state_q, state_d;
  logic [BINW-1:0] cnt_q, cnt_d, cur;
  logic acc, last, good, err, load;
  logic vld_q, vld_d, err_q, ovr_q;
  result_t peak, res_q;
  assign acc = bus.in_valid && (state_q == SCAN || bus.in_sop);
  assign cur = bus.in_sop ? '0 : cnt_q;
  assign last = &cur;
  assign good = acc && bus.in_eop && last;
  // late sop, early eop and missing eop all discard the frame
  assign err = acc && ((state_q == SCAN && bus.in_sop) || (bus.in_eop != last));
  assign load = good && (!vld_q || bus.res_ready);
  always_comb begin
    state_d = acc ? ((bus.in_eop || last) ? IDLE : SCAN) : state_q;
    cnt_d = acc ? cur + 1'b1 : cnt_q;
    vld_d = load || (vld_q && !bus.res_ready);
  end
  peak_cmp #(.BIN_LO(BIN_LO), .BIN_HI(BIN_HI)) u_cmp (
    .clk(sys_clk),
    .rst(sys_rst),
    .en_i(acc),
    .start_i(acc && bus.in_sop),
    .bin_i(cur),
    .data_i(bus.in_data),
    .peak_o(peak)
  );
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
      ovr_q <= 1'b0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
      err_q <= err;
      ovr_q <= good && !load;
      res_q <= load ? peak : res_q;
    end
  assign bus.res_valid = vld_q;
  assign bus.res_bin = res_q.bin;
  assign bus.res_power = res_q.power;
  assign bus.frame_err = err_q;
  assign bus.res_overrun = ovr_q;
`ifdef PEAK_NEIGHBOR_EN
  assign bus.res_left = res_q.left;
  assign bus.res_right = res_q.right;
`endif
endmodule

// File: doc/spectrum_peak.md
# spectrum_peak

Streaming peak search on the FFT power spectrum. Consumes one power sample per bin (re² + im²) from the FFT magnitude stage together with the FFT frame markers. Tracks the strongest bin inside a programmable search window and, after each complete frame, presents the peak bin index and power through a one-entry valid/ready result register. The result feeds the frequency-measurement and display logic.

## Interface
- DW, 24, power sample width (unsigned)
- N, 1024, FFT frame length in samples (power of two, ≥ 8)
- BIN_LO, 1, first bin searched (default excludes DC)
- BIN_HI, N/2-1, last bin searched (BIN_LO ≤ BIN_HI < N)

- sys_clk  in  1  single clock; all logic on rising edge
- sys_rst  in  1  asynchronous, active-high reset
- in_valid  in  1  sample qualifier; no backpressure, one bin per valid cycle
- in_sop  in  1  first bin of frame, qualified by in_valid
- in_eop  in  1  last bin of frame, qualified by in_valid
- in_data  in  DW  bin power
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_bin  out  log2(N)  peak bin index
- res_power  out  DW  peak power
- res_left / res_right  out  DW  neighbour powers (PEAK_NEIGHBOR_EN only)
- frame_err  out  1  one-cycle pulse: malformed frame discarded
- res_overrun  out  1  one-cycle pulse: new result dropped, slot full

## Operation
- States: IDLE (wait sop), SCAN (counting bins). Reset → IDLE, counters/max cleared.
- IDLE: valid sample without sop ignored. valid+sop → bin index 0 processed, go SCAN.
- SCAN: bin counter increments per valid sample. Samples with BIN_LO ≤ bin ≤ BIN_HI compared against running max; update only on strictly greater (ties keep lowest bin). Running max initialised to 0, bin to BIN_LO, at every sop.
- Frame end: valid+eop at bin N-1 → good frame, commit result, go IDLE.
- Errors (pulse frame_err, discard, no commit): eop at bin ≠ N-1 → IDLE; sop while in SCAN → discard current, restart with this sample as bin 0 (stay SCAN); bin N-1 reached without eop → IDLE.
- Commit: if res_valid=0, or res_valid=1 and res_ready=1 same cycle → load result, res_valid=1. Else keep old result, pulse res_overrun.
- Handshake: result held stable while res_valid && !res_ready; res_valid drops the cycle after res_valid && res_ready unless a commit reloads it that cycle.
- Comparison unsigned DW bits; no arithmetic widening.

## Timing
- All outputs 0 after reset.
- Latency: res_valid rises the cycle after the accepted eop sample (1 cycle).
- frame_err / res_overrun asserted the cycle after the offending sample, for exactly one cycle.
- Throughput: one sample per clock, back-to-back frames (sop directly after eop) supported with no gap.
- Reset mid-frame or mid-handshake: frame discarded, res_valid cleared immediately (asynchronous).

## Configuration
- PEAK_NEIGHBOR_EN defined: res_left/res_right ports exist. res_left = power of bin peak-1, res_right = power of bin peak+1, captured from the stream (right captured one sample after a new max; pending capture cancelled by a later max). Neighbour outside [BIN_LO, BIN_HI] reads 0. Committed together with res_bin.
- Undefined: ports and neighbour registers absent; all other behaviour identical.

## Structure
- Package spectrum_pkg: DW, N, BINW = log2(N) constants, state enum {IDLE, SCAN}, result struct (bin, power, left, right).
- Sub-module peak_cmp: running-max register, strict-greater compare, neighbour capture; top handles FSM, bin counter, framing checks, result register.

## Test plan
- Single frame, bin 37 = 5000, others 100 → res_valid 1 cycle after eop, res_bin=37, res_power=5000; with macro res_left=res_right=100.
- Equal peaks 900 at bins 10 and 200 → res_bin=10.
- Bin 0 = 0xFFFFFF (DC), bin 5 = 50, rest 0 → res_bin=5 (DC excluded); bin 600 = 0xFFFFFF ignored (> BIN_HI).
- eop at bin 500 → frame_err pulse, no res_valid; sop at bin 300 then full frame → frame_err once, result from second frame only.
- Two back-to-back frames, res_ready=0 → first result held, res_overrun pulse at second eop; res_ready=1 on the second commit cycle → second result loaded, no overrun.
- sys_rst asserted mid-SCAN with res_valid=1 → all outputs 0 immediately; next full frame produces correct result.
